eth_tx_arb: RTL and testbench

ETH_TX_ARB -- requirements
Module: eth_tx_arb

---
 rtl/eth_tx_arb_if.sv | 35 +++
 rtl/eth_tx_arb.sv | 207 ++++++++++++++++++++
 tb/tb_eth_tx_arb.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arb_if.sv
// Requester and transmit-FIFO side signals of eth_tx_arb, grouped into one bundle.
// slave: arbiter view; master: requester / FIFO-side view.
interface eth_tx_arb_if;
    logic       Req0_Valid;
    logic [7:0] Req0_Data;
    logic       Req0_Last;
    logic       Req0_Ready;
    logic       Req1_Valid;
    logic [7:0] Req1_Data;
    logic       Req1_Last;
    logic       Req1_Ready;
    logic [9:0] Eth_Byte;
    logic       Eth_Byte_Valid;
    logic [1:0] Grant;
    logic       Busy;
    logic       Underrun;
    logic       Oversize;
    logic       Pkt_Done;

    modport slave (
        input  Req0_Valid, Req0_Data, Req0_Last,
        input  Req1_Valid, Req1_Data, Req1_Last,
        output Req0_Ready, Req1_Ready,
        output Eth_Byte, Eth_Byte_Valid, Grant, Busy,
        output Underrun, Oversize, Pkt_Done
    );

    modport master (
        output Req0_Valid, Req0_Data, Req0_Last,
        output Req1_Valid, Req1_Data, Req1_Last,
        input  Req0_Ready, Req1_Ready,
        input  Eth_Byte, Eth_Byte_Valid, Grant, Busy,
        input  Underrun, Oversize, Pkt_Done
    );
endinterface

// File: rtl/eth_tx_arb.sv
// Two-requester round-robin Ethernet transmit arbiter with inter-packet gap,
// length limiting and underrun handling. Short-frame padding to 46 bytes is
// compiled in only when ETH_TX_ARB_PAD_EN is defined. pGAP_CYCLES must be >= 1.
module eth_tx_arb #(
    parameter int pGAP_CYCLES = 64,
    parameter int pMAX_LEN    = 1500
) (
    input  logic         Clk,
    input  logic         Rst,
    eth_tx_arb_if.slave  bus
);

`ifdef ETH_TX_ARB_PAD_EN
    typedef enum logic [2:0] {IDLE, XFER, PAD, DRAIN, GAP} state_t;
    localparam logic [10:0] PAD_LEN = 11'd46;
`else
    typedef enum logic [2:0] {IDLE, XFER, DRAIN, GAP} state_t;
`endif

    localparam int          GW       = (pGAP_CYCLES > 1) ? $clog2(pGAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(pGAP_CYCLES - 1);
    localparam logic [10:0] MAX_LEN  = 11'(pMAX_LEN);

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_srv_q, last_srv_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [9:0]    byte_q, byte_d;
    logic          byte_vld_q, byte_vld_d;
    logic          underrun_q, underrun_d;
    logic          oversize_q, oversize_d;
    logic          done_q, done_d;

    logic [1:0]    req_valid;
    logic [1:0]    req_last;
    logic [7:0]    req_data [2];
    logic [1:0]    ready;
    logic          accepting;
    logic          winner;
    logic          sel;
    logic          s_valid;
    logic          s_last;
    logic [7:0]    s_data;
    logic [10:0]   cnt_nxt;
    logic          sop;

    assign req_valid   = {bus.Req1_Valid, bus.Req0_Valid};
    assign req_last    = {bus.Req1_Last,  bus.Req0_Last};
    assign req_data[0] = bus.Req0_Data;
    assign req_data[1] = bus.Req1_Data;

    // On a tie the requester that was not served last wins.
    assign winner = (req_valid == 2'b11) ? ~last_srv_q : ~req_valid[0];

    assign sel     = grant_q[1];
    assign s_valid = req_valid[sel];
    assign s_last  = req_last[sel];
    assign s_data  = req_data[sel];
    assign cnt_nxt = cnt_q + 11'd1;
    assign sop     = (cnt_q == 11'd0);

    assign accepting = (state_q == XFER) || (state_q == DRAIN);

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready[gi] = grant_q[gi] & accepting;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            last_srv_q <= 1'b1;
            cnt_q      <= '0;
            gap_q      <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            underrun_q <= 1'b0;
            oversize_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_srv_q <= last_srv_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            underrun_q <= underrun_d;
            oversize_q <= oversize_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_srv_d = last_srv_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        byte_d     = '0;
        byte_vld_d = 1'b0;
        underrun_d = 1'b0;
        oversize_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d    = winner ? 2'b10 : 2'b01;
                    last_srv_d = winner;
                    cnt_d      = '0;
                    gap_d      = '0;
                    state_d    = XFER;
                end
            end

            XFER: begin
                byte_vld_d = 1'b1;
                cnt_d      = cnt_nxt;
                if (s_valid) begin
                    if (s_last) begin
`ifdef ETH_TX_ARB_PAD_EN
                        if (cnt_nxt < PAD_LEN) begin
                            byte_d  = {sop, 1'b0, s_data};
                            state_d = PAD;
                        end else begin
                            byte_d  = {sop, 1'b1, s_data};
                            done_d  = 1'b1;
                            gap_d   = '0;
                            state_d = GAP;
                        end
`else
                        byte_d  = {sop, 1'b1, s_data};
                        done_d  = 1'b1;
                        gap_d   = '0;
                        state_d = GAP;
`endif
                    end else if (cnt_nxt == MAX_LEN) begin
                        // Truncate here; the rest of the packet is swallowed in DRAIN.
                        byte_d     = {sop, 1'b1, s_data};
                        oversize_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        byte_d = {sop, 1'b0, s_data};
                    end
                end else begin
                    // Requester starved mid-packet: close the frame with a dummy byte.
                    byte_d     = {sop, 1'b1, 8'h00};
                    underrun_d = 1'b1;
                    done_d     = 1'b1;
                    gap_d      = '0;
                    state_d    = GAP;
                end
            end

`ifdef ETH_TX_ARB_PAD_EN
            PAD: begin
                byte_vld_d = 1'b1;
                cnt_d      = cnt_nxt;
                if (cnt_nxt == PAD_LEN) begin
                    byte_d  = {1'b0, 1'b1, 8'h00};
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    byte_d = {1'b0, 1'b0, 8'h00};
                end
            end
`endif

            DRAIN: begin
                if (s_valid && s_last) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Req0_Ready     = ready[0];
    assign bus.Req1_Ready     = ready[1];
    assign bus.Eth_Byte       = byte_q;
    assign bus.Eth_Byte_Valid = byte_vld_q;
    assign bus.Grant          = grant_q;
    assign bus.Busy           = (state_q != IDLE);
    assign bus.Underrun       = underrun_q;
    assign bus.Oversize       = oversize_q;
    assign bus.Pkt_Done       = done_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed self-checking bench for eth_tx_arb (pGAP_CYCLES=4, pMAX_LEN=64).
// Expectations follow ETH_TX_ARB_PAD_EN when the bench is built with it.
module tb_eth_tx_arb;
    logic Clk = 1'b0;
    logic Rst = 1'b1;

    eth_tx_arb_if bus();

    eth_tx_arb #(.pGAP_CYCLES(4), .pMAX_LEN(64)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] b;
        logic       done;
        logic [1:0] g;
        int         cyc;
    } cap_t;

    cap_t cap[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_under, n_over, n_done;
    int   gap_len, gap_cnt, gap_ready_err, other_err, hole_err;
    bit   gap_run, prev_mid;

    always @(posedge Clk) cyc <= cyc + 1;

    // Output monitor: records emitted bytes and status activity at the falling edge.
    always @(negedge Clk) begin
        if (bus.Eth_Byte_Valid)
            cap.push_back('{b: bus.Eth_Byte, done: bus.Pkt_Done, g: bus.Grant, cyc: cyc});
        if (bus.Underrun) n_under++;
        if (bus.Oversize) n_over++;
        if (bus.Pkt_Done) n_done++;
        if ((bus.Grant == 2'b01 && bus.Req1_Ready) || (bus.Grant == 2'b10 && bus.Req0_Ready))
            other_err++;
        if (prev_mid && !bus.Eth_Byte_Valid) hole_err++;
        prev_mid = bus.Eth_Byte_Valid && !bus.Eth_Byte[8];
        if (bus.Eth_Byte_Valid && bus.Eth_Byte[8]) begin
            gap_run = 1'b1;
            gap_cnt = 1;
        end else if (gap_run) begin
            if (bus.Busy) gap_cnt++;
            else begin
                gap_run = 1'b0;
                gap_len = gap_cnt;
            end
        end
        if (gap_run && (bus.Req0_Ready || bus.Req1_Ready)) gap_ready_err++;
        if (Rst) begin
            prev_mid = 1'b0;
            gap_run  = 1'b0;
        end
    end

    task automatic clear_cap();
        cap.delete();
        n_under = 0; n_over = 0; n_done = 0;
        gap_len = 0; gap_cnt = 0; gap_ready_err = 0; other_err = 0; hole_err = 0;
        gap_run = 1'b0; prev_mid = 1'b0;
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
        if (r == 0) begin
            bus.Req0_Valid = v; bus.Req0_Data = d; bus.Req0_Last = l;
        end else begin
            bus.Req1_Valid = v; bus.Req1_Data = d; bus.Req1_Last = l;
        end
    endtask

    // Streams n bytes b0, b0+1, ... from requester r; stops early after stop_at accepts,
    // optionally raising Rst at that point. Bounded to 2000 cycles.
    task automatic drive(input int r, input int n, input logic [7:0] b0, input int stop_at,
                         input bit rst_after, output int acc);
        int  budget = 0;
        bit  hs;
        acc = 0;
        while (acc < n && acc < stop_at && budget < 2000) begin
            set_req(r, 1'b1, b0 + 8'(acc), acc == n - 1);
            @(negedge Clk);
            hs = (r == 0) ? bus.Req0_Ready : bus.Req1_Ready;
            @(posedge Clk); #1;
            if (hs) acc++;
            budget++;
        end
        if (rst_after) Rst = 1'b1;
        set_req(r, 1'b0, 8'h00, 1'b0);
        $display("req%0d: %0d bytes accepted", r, acc);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge Clk);
            if (!bus.Busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    task automatic test_reset();
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if (bus.Eth_Byte !== 10'h000 || bus.Eth_Byte_Valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_byte: got %h/%b, want 000/0", bus.Eth_Byte, bus.Eth_Byte_Valid);
        end
        n_checks++;
        if ({bus.Req1_Ready, bus.Req0_Ready} !== 2'b00 || bus.Grant !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_ready_grant: got rdy=%b grant=%b, want 00/00",
                     {bus.Req1_Ready, bus.Req0_Ready}, bus.Grant);
        end
        n_checks++;
        if ({bus.Busy, bus.Underrun, bus.Oversize, bus.Pkt_Done} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_status: got %b, want 0000",
                     {bus.Busy, bus.Underrun, bus.Oversize, bus.Pkt_Done});
        end
        @(posedge Clk); #1 Rst = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_single();
        int acc;
        bit ok;
        logic [9:0] exp;
        clear_cap();
        drive(0, 50, 8'h00, 1000, 1'b0, acc);
        wait_idle(ok);
        n_checks++;
        if (!ok || acc != 50) begin
            n_errors++;
            $display("FAIL single_accept: got acc=%0d idle=%0d, want 50/1", acc, ok);
        end
        n_checks++;
        if (cap.size() != 50) begin
            n_errors++;
            $display("FAIL single_len: got %0d, want 50", cap.size());
        end
        for (int i = 0; i < cap.size() && i < 50; i++) begin
            exp = {1'(i == 0), 1'(i == 49), 8'(i)};
            n_checks++;
            if (cap[i].b !== exp || cap[i].done !== exp[8] || cap[i].g !== 2'b01) begin
                n_errors++;
                $display("FAIL single_byte[%0d]: got %h done=%b g=%b, want %h done=%b g=01",
                         i, cap[i].b, cap[i].done, cap[i].g, exp, exp[8]);
            end
        end
        n_checks++;
        if (n_done != 1 || n_under != 0 || n_over != 0) begin
            n_errors++;
            $display("FAIL single_pulses: got done=%0d under=%0d over=%0d, want 1/0/0",
                     n_done, n_under, n_over);
        end
        n_checks++;
        if (gap_len != 4 || gap_ready_err != 0 || other_err != 0 || hole_err != 0) begin
            n_errors++;
            $display("FAIL single_gap: got gap=%0d rdy_err=%0d other=%0d holes=%0d, want 4/0/0/0",
                     gap_len, gap_ready_err, other_err, hole_err);
        end
    endtask

    task automatic test_round_robin();
        int acc0, acc1;
        bit ok;
        logic [9:0] exp;
        do_reset();
        clear_cap();
        fork
            drive(0, 60, 8'h00, 1000, 1'b0, acc0);
            drive(1, 60, 8'h80, 1000, 1'b0, acc1);
        join
        wait_idle(ok);
        n_checks++;
        if (!ok || cap.size() != 120) begin
            n_errors++;
            $display("FAIL rr_len: got %0d idle=%0d, want 120/1", cap.size(), ok);
        end
        for (int i = 0; i < cap.size() && i < 120; i++) begin
            exp = {1'((i % 60) == 0), 1'((i % 60) == 59), 8'(i % 60) + ((i < 60) ? 8'h00 : 8'h80)};
            n_checks++;
            if (cap[i].b !== exp || cap[i].g !== ((i < 60) ? 2'b01 : 2'b10)) begin
                n_errors++;
                $display("FAIL rr_byte[%0d]: got %h g=%b, want %h g=%b",
                         i, cap[i].b, cap[i].g, exp, (i < 60) ? 2'b01 : 2'b10);
            end
        end
        n_checks++;
        if (cap.size() == 120 && (cap[60].cyc - cap[59].cyc) != 6) begin
            n_errors++;
            $display("FAIL rr_gap: got %0d cycles EOP->SOP, want 6", cap[60].cyc - cap[59].cyc);
        end
        n_checks++;
        if (gap_ready_err != 0 || other_err != 0 || hole_err != 0 || n_done != 2) begin
            n_errors++;
            $display("FAIL rr_ready: got rdy_err=%0d other=%0d holes=%0d done=%0d, want 0/0/0/2",
                     gap_ready_err, other_err, hole_err, n_done);
        end
    endtask

    task automatic test_underrun();
        int acc;
        bit ok;
        logic [9:0] exp;
        clear_cap();
        drive(1, 60, 8'h40, 10, 1'b0, acc);
        wait_idle(ok);
        n_checks++;
        if (!ok || cap.size() != 11) begin
            n_errors++;
            $display("FAIL underrun_len: got %0d idle=%0d, want 11/1", cap.size(), ok);
        end
        for (int i = 0; i < cap.size() && i < 11; i++) begin
            exp = (i == 10) ? 10'h100 : {1'(i == 0), 1'b0, 8'h40 + 8'(i)};
            n_checks++;
            if (cap[i].b !== exp || cap[i].done !== exp[8] || cap[i].g !== 2'b10) begin
                n_errors++;
                $display("FAIL underrun_byte[%0d]: got %h done=%b g=%b, want %h done=%b g=10",
                         i, cap[i].b, cap[i].done, cap[i].g, exp, exp[8]);
            end
        end
        n_checks++;
        if (n_under != 1 || n_over != 0 || n_done != 1 || gap_len != 4) begin
            n_errors++;
            $display("FAIL underrun_pulses: got under=%0d over=%0d done=%0d gap=%0d, want 1/0/1/4",
                     n_under, n_over, n_done, gap_len);
        end
    endtask

    task automatic test_oversize();
        int acc;
        bit ok;
        logic [9:0] exp;
        clear_cap();
        drive(0, 70, 8'h00, 1000, 1'b0, acc);
        wait_idle(ok);
        n_checks++;
        if (!ok || acc != 70) begin
            n_errors++;
            $display("FAIL oversize_drain: got acc=%0d idle=%0d, want 70/1", acc, ok);
        end
        n_checks++;
        if (cap.size() != 64) begin
            n_errors++;
            $display("FAIL oversize_len: got %0d, want 64", cap.size());
        end
        for (int i = 0; i < cap.size() && i < 64; i++) begin
            exp = {1'(i == 0), 1'(i == 63), 8'(i)};
            n_checks++;
            if (cap[i].b !== exp || cap[i].done !== exp[8]) begin
                n_errors++;
                $display("FAIL oversize_byte[%0d]: got %h done=%b, want %h done=%b",
                         i, cap[i].b, cap[i].done, exp, exp[8]);
            end
        end
        n_checks++;
        if (n_over != 1 || n_under != 0 || n_done != 1) begin
            n_errors++;
            $display("FAIL oversize_pulses: got over=%0d under=%0d done=%0d, want 1/0/1",
                     n_over, n_under, n_done);
        end
    endtask

    task automatic test_exact_max();
        int acc;
        bit ok;
        clear_cap();
        drive(0, 64, 8'h10, 1000, 1'b0, acc);
        wait_idle(ok);
        n_checks++;
        if (!ok || cap.size() != 64 || n_over != 0 || n_done != 1) begin
            n_errors++;
            $display("FAIL exact_max: got len=%0d over=%0d done=%0d idle=%0d, want 64/0/1/1",
                     cap.size(), n_over, n_done, ok);
        end
        n_checks++;
        if (cap.size() == 64 && cap[63].b !== {2'b01, 8'h4F}) begin
            n_errors++;
            $display("FAIL exact_max_eop: got %h, want 14f", cap[63].b);
        end
    endtask

    task automatic test_pad();
        int acc;
        bit ok;
        int exp_len;
        logic [9:0] exp;
`ifdef ETH_TX_ARB_PAD_EN
        exp_len = 46;
`else
        exp_len = 10;
`endif
        clear_cap();
        drive(0, 10, 8'hA0, 1000, 1'b0, acc);
        wait_idle(ok);
        n_checks++;
        if (!ok || cap.size() != exp_len) begin
            n_errors++;
            $display("FAIL pad_len: got %0d idle=%0d, want %0d/1", cap.size(), ok, exp_len);
        end
        for (int i = 0; i < cap.size() && i < exp_len; i++) begin
            exp = {1'(i == 0), 1'(i == exp_len - 1), (i < 10) ? 8'hA0 + 8'(i) : 8'h00};
            n_checks++;
            if (cap[i].b !== exp || cap[i].done !== exp[8]) begin
                n_errors++;
                $display("FAIL pad_byte[%0d]: got %h done=%b, want %h done=%b",
                         i, cap[i].b, cap[i].done, exp, exp[8]);
            end
        end
        n_checks++;
        if (n_done != 1 || gap_len != 4 || hole_err != 0) begin
            n_errors++;
            $display("FAIL pad_status: got done=%0d gap=%0d holes=%0d, want 1/4/0",
                     n_done, gap_len, hole_err);
        end
    endtask

    task automatic test_reset_mid();
        int acc, acc0, acc1;
        bit ok;
        bit eop_seen;
        clear_cap();
        drive(0, 60, 8'h00, 20, 1'b1, acc);
        @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if (bus.Eth_Byte !== 10'h000 || bus.Eth_Byte_Valid !== 1'b0 || bus.Grant !== 2'b00 ||
            bus.Busy !== 1'b0 || {bus.Req1_Ready, bus.Req0_Ready} !== 2'b00 ||
            {bus.Underrun, bus.Oversize, bus.Pkt_Done} !== 3'b000) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got byte=%h v=%b g=%b busy=%b rdy=%b st=%b, want all 0",
                     bus.Eth_Byte, bus.Eth_Byte_Valid, bus.Grant, bus.Busy,
                     {bus.Req1_Ready, bus.Req0_Ready}, {bus.Underrun, bus.Oversize, bus.Pkt_Done});
        end
        eop_seen = 1'b0;
        foreach (cap[i]) if (cap[i].b[8]) eop_seen = 1'b1;
        n_checks++;
        if (cap.size() != 20 || eop_seen || n_done != 0) begin
            n_errors++;
            $display("FAIL rstmid_abort: got len=%0d eop=%0d done=%0d, want 20/0/0",
                     cap.size(), eop_seen, n_done);
        end
        @(posedge Clk); #1 Rst = 1'b0;
        clear_cap();
        fork
            drive(0, 50, 8'h00, 1000, 1'b0, acc0);
            drive(1, 50, 8'h80, 1000, 1'b0, acc1);
        join
        wait_idle(ok);
        n_checks++;
        if (!ok || cap.size() != 100) begin
            n_errors++;
            $display("FAIL rstmid_len: got %0d idle=%0d, want 100/1", cap.size(), ok);
        end
        n_checks++;
        if (cap.size() > 0 && (cap[0].b !== 10'h200 || cap[0].g !== 2'b01)) begin
            n_errors++;
            $display("FAIL rstmid_first: got %h g=%b, want 200 g=01", cap[0].b, cap[0].g);
        end
        n_checks++;
        if (cap.size() == 100 && (cap[50].b !== 10'h280 || cap[50].g !== 2'b10)) begin
            n_errors++;
            $display("FAIL rstmid_second: got %h g=%b, want 280 g=10", cap[50].b, cap[50].g);
        end
    endtask

    initial begin
        clear_cap();
        test_reset();
        test_single();
        test_round_robin();
        test_underrun();
        test_oversize();
        test_exact_max();
        test_pad();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
